// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared types for the multiplier arbiter: FSM state encoding, the tag that
// travels alongside each multiplication, and the statistics counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int STAT_W = 16;
  // Sized for the largest supported requester count (8), so the packed tag
  // type stays fixed regardless of the NUM_REQ chosen at instantiation.
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            sign;
  } tag_t;

endpackage

// File: rtl/mult_arbiter_tag_pipe.sv
// -----------------------------------------------------------------------------
// mult_tag_pipe
// Fixed-depth shift register, cleared by asynchronous reset. Used to carry
// the request tag alongside the multiplier so it exits aligned with the
// product.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (clears every stage)
//   d        in   WIDTH  stage-0 input
//   q        out  WIDTH  last-stage output (d delayed by DEPTH clocks)
// -----------------------------------------------------------------------------
module mult_tag_pipe #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Round-robin scheduler sharing one pipelined OP_W x OP_W multiplier among
// NUM_REQ requesters. At most one issue per clock; each product returns,
// with its requester's sign bit on top, to the requester that issued it.
// A drain/idle handshake lets software quiesce the multiplier.
//
//   state | meaning
//   RUN   | granting requests
//   DRAIN | no grants, waiting for in-flight operations to return
//   IDLE  | pipe empty, no grants until drain_req drops
//
// Optional feature macro: MULT_ARB_STATS_EN (per-requester grant counters,
// adds stats_clr / grant_cnt ports).
// Ports:
//   clock, reset_n          clock, async active-low reset
//   req_valid/req_ready     per-requester handshake (ready is one-hot grant)
//   req_a/req_b/req_sign    packed operands, requester i at [i*OP_W +: OP_W]
//   mult_in_valid/a/b       registered issue to the multiplier
//   mult_result             product, LATENCY clocks after mult_in_valid
//   rsp_valid/rsp_data      one-hot response strobe, shared {sign, product}
//   drain_req/idle          quiesce request level / high in IDLE
//   stats_clr/grant_cnt     (MULT_ARB_STATS_EN only) clear / 16-bit counters
// -----------------------------------------------------------------------------
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 24,
  parameter int DATA_W  = 48,
  parameter int LATENCY = 9
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_sign,
  output logic                   mult_in_valid,
  output logic [OP_W-1:0]        mult_a,
  output logic [OP_W-1:0]        mult_b,
  input  logic [DATA_W-1:0]      mult_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [DATA_W:0]        rsp_data,
  input  logic                   drain_req,
  output logic                   idle
`ifdef MULT_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam int IF_W  = $clog2(LATENCY + 3);
  localparam int TAG_W = $bits(tag_t);

  state_t                r_state, w_state_next;
  logic [ID_W-1:0]       r_rr_ptr, w_grant_idx, w_scan;
  logic [(1<<ID_W)-1:0]  w_req_ext;
  logic                  w_grant_any, w_grant_en, w_hs;
  logic [NUM_REQ-1:0]    w_grant_oh, w_rsp_oh;
  logic [OP_W-1:0]       w_sel_a, w_sel_b;
  logic                  w_sel_sign;
  logic                  r_mult_in_valid, r_issue_sign;
  logic [OP_W-1:0]       r_mult_a, r_mult_b;
  logic [ID_W-1:0]       r_issue_id;
  tag_t                  w_tag_in, w_tag_out;
  logic [TAG_W-1:0]      w_tag_q;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_W:0]       r_rsp_data;
  logic [IF_W-1:0]       r_in_flight;

  // Round-robin search starting at r_rr_ptr; requests are zero-extended to
  // the full ID_W index range so the scan index always selects in range.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = req_valid;
    w_grant_any            = 1'b0;
    w_grant_idx            = '0;
    w_scan                 = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant_any && w_req_ext[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan;
      end
      w_scan = (w_scan == ID_W'(NUM_REQ - 1)) ? '0 : w_scan + 1'b1;
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_sign = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_any && (w_grant_idx == ID_W'(i))) begin
        w_grant_oh[i] = 1'b1;
        w_sel_a       = req_a[i*OP_W +: OP_W];
        w_sel_b       = req_b[i*OP_W +: OP_W];
        w_sel_sign    = req_sign[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    idle         = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_grant_en = !drain_req;
        if (drain_req) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_in_flight == '0) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        idle = 1'b1;
        if (!drain_req) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_hs      = w_grant_en & w_grant_any;
  assign req_ready = {NUM_REQ{w_grant_en}} & w_grant_oh;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hs) r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // Operands hold when nothing issues; only mult_in_valid drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mult_in_valid <= 1'b0;
      r_mult_a        <= '0;
      r_mult_b        <= '0;
      r_issue_id      <= '0;
      r_issue_sign    <= 1'b0;
    end else begin
      r_mult_in_valid <= w_hs;
      if (w_hs) begin
        r_mult_a     <= w_sel_a;
        r_mult_b     <= w_sel_b;
        r_issue_id   <= w_grant_idx;
        r_issue_sign <= w_sel_sign;
      end
    end
  end

  assign mult_in_valid = r_mult_in_valid;
  assign mult_a        = r_mult_a;
  assign mult_b        = r_mult_b;

  // Tag enters with mult_in_valid and leaves in the cycle mult_result is valid.
  assign w_tag_in = {r_mult_in_valid, r_issue_id, r_issue_sign};

  mult_tag_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (w_tag_in),
    .q       (w_tag_q)
  );

  assign w_tag_out = w_tag_q;

  always_comb begin
    w_rsp_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) w_rsp_oh[i] = (w_tag_out.id == ID_W'(i));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else if (w_tag_out.valid) begin
      r_rsp_valid <= w_rsp_oh;
      r_rsp_data  <= {w_tag_out.sign, mult_result};
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_in_flight <= '0;
    end else begin
      case ({w_hs, |r_rsp_valid})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters; clear beats a same-cycle grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          r_grant_cnt[i] <= '0;
        else if (w_hs && w_grant_oh[i] && (r_grant_cnt[i] != '1))
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*STAT_W +: STAT_W] = r_grant_cnt[g];
  end
`endif

endmodule
